// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART TX byte port among NUM_REQ sources.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_data/req_last     per-source byte stream (source i at req_data[8i+7:8i])
//   req_ready                       per-source accept, one-hot or zero
//   tx_valid/tx_data/tx_ready       byte port to the UART transmitter
//   busy                            a grant is held
//   grant_id                        current or most recent owner
//   pkt_done                        pulses on the cycle the last byte of a packet is accepted
// Optional feature: define UART_ARB_TIMEOUT_EN to release a stalled owner after LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int IDW          = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic [IDW-1:0]       grant_id,
   output logic                 pkt_done
);
   localparam int P = 2 ** IDW;
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t         state;
   logic [IDW-1:0] rr_ptr, owner, sel, nxt, cand;
   logic [P-1:0]   valid_pad, last_pad;
   logic [8*P-1:0] data_pad;
   logic           locked, xfer, fin, expire;
   int             j;

   if (NUM_REQ < 2 || NUM_REQ > 8 || P < NUM_REQ || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_param
      $error("uart_tx_arbiter: invalid parameters");
   end

   // Padding to 2**IDW lets owner index the request vectors at its natural width.
   assign valid_pad = P'(req_valid);
   assign last_pad  = P'(req_last);
   assign data_pad  = (8*P)'(req_data);
   assign locked    = state == LOCKED;
   assign xfer      = locked && valid_pad[owner] && tx_ready;
   assign fin       = xfer && last_pad[owner];
   assign nxt       = owner == IDW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
   assign tx_valid  = locked && valid_pad[owner];
   assign tx_data   = locked ? data_pad[{owner, 3'b000} +: 8] : 8'h00;
   assign busy      = locked;
   assign grant_id  = owner;
   assign pkt_done  = fin;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = locked && tx_ready && owner == IDW'(i);
   end

   // Scan from farthest to nearest so the candidate closest to rr_ptr is the final assignment.
   always_comb begin
      sel  = rr_ptr;
      cand = '0;
      j    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         cand = IDW'(j);
         if (valid_pad[cand]) sel = cand;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0] idle_cnt;
   assign expire = locked && !valid_pad[owner] && idle_cnt == 16'(LOCK_TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst || !locked || xfer)
         idle_cnt <= '0;
      else if (!valid_pad[owner])
         idle_cnt <= idle_cnt + 16'd1;
   end
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
      end else if (!locked) begin
         if (|req_valid) begin
            state <= LOCKED;
            owner <= sel;
         end
      end else if (fin || expire) begin
         state  <= IDLE;
         rr_ptr <= nxt;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of uart_tx_arbiter with three queue-driven byte sources.
module tb_uart_tx_arbiter;
   localparam int N = 3;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [8*N-1:0] req_data = '0;
   logic           tx_valid, busy, pkt_done;
   logic           tx_ready = 1'b1;
   logic [7:0]     tx_data;
   logic [1:0]     grant_id;

   logic [7:0] qd [N][$];
   logic       ql [N][$];
   logic [N-1:0] took = '0;
   logic [7:0] log_q [$];
   logic [1:0] gnt_q [$];
   int         pkts = 0;
   logic       prev_busy = 1'b0;
   int         checks = 0;
   int         failures = 0;
   int         stall;
   logic       stable;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(16), .IDW(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .grant_id(grant_id), .pkt_done(pkt_done)
   );

   always @(negedge clk) begin
      took = req_valid & req_ready;
      if (tx_valid && tx_ready) log_q.push_back(tx_data);
      if (pkt_done) pkts++;
      if (busy && !prev_busy) gnt_q.push_back(grant_id);
      prev_busy = busy;
   end

   always @(posedge clk) begin
      #2;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            qd[i].delete();
            ql[i].delete();
         end else if (took[i] && qd[i].size() > 0) begin
            void'(qd[i].pop_front());
            void'(ql[i].pop_front());
         end
         req_valid[i]       = qd[i].size() > 0;
         req_data[8*i +: 8] = req_valid[i] ? qd[i][0] : 8'h00;
         req_last[i]        = req_valid[i] && ql[i][0];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic at_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input logic [7:0] d, input logic l);
      qd[s].push_back(d);
      ql[s].push_back(l);
   endtask

   task automatic clear_logs();
      log_q.delete();
      gnt_q.delete();
      pkts = 0;
   endtask

   task automatic do_reset();
      at_pos();
      rst = 1'b1;
      at_pos();
      at_pos();
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_pkts(input int n, input int lim);
      for (int k = 0; k < lim && pkts < n; k++) tick();
   endtask

   function automatic logic [63:0] packed_log();
      logic [63:0] v = '0;
      foreach (log_q[i]) v = {v[55:0], log_q[i]};
      return v;
   endfunction

   function automatic logic [63:0] packed_gnt();
      logic [63:0] v = '0;
      foreach (gnt_q[i]) v = {v[59:0], 2'b00, gnt_q[i]};
      return v;
   endfunction

   initial begin
      repeat (3) at_pos();
      tick();
      chk("rst_busy", 64'(busy), 0);
      chk("rst_grant", 64'(grant_id), 0);
      chk("rst_tx_valid", 64'(tx_valid), 0);
      chk("rst_tx_data", 64'(tx_data), 0);
      chk("rst_req_ready", 64'(req_ready), 0);
      chk("rst_pkt_done", 64'(pkt_done), 0);
      at_pos();
      rst = 1'b0;
      clear_logs();

      push(0, 8'h78, 1'b0); push(0, 8'h79, 1'b0); push(0, 8'h7A, 1'b1);
      for (int k = 0; k < 20 && !pkt_done; k++) tick();
      chk("t1_done", 64'(pkt_done), 1);
      chk("t1_busy_at_done", 64'(busy), 1);
      tick();
      chk("t1_idle_after", 64'(busy), 0);
      chk("t1_grant", 64'(grant_id), 0);
      repeat (3) tick();
      chk("t1_nbytes", 64'(log_q.size()), 3);
      chk("t1_bytes", packed_log(), 64'h78797A);
      chk("t1_pkts", 64'(pkts), 1);

      do_reset();
      push(0, 8'h0D, 1'b0); push(0, 8'h0A, 1'b1);
      push(1, 8'h31, 1'b0); push(1, 8'h35, 1'b0); push(1, 8'h31, 1'b0);
      push(1, 8'h3E, 1'b0); push(1, 8'h20, 1'b1);
      wait_pkts(2, 40);
      chk("t2_nbytes", 64'(log_q.size()), 7);
      chk("t2_bytes", packed_log(), 64'h0D0A3135313E20);
      chk("t2_grants", packed_gnt(), 64'h01);

      do_reset();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push(i, 8'(64 + i), 1'b1);
      for (int k = 0; k < 20 && !pkt_done; k++) tick();
      repeat (10) tick();
      chk("t3_pkts_12cyc", 64'(pkts), 6);
      chk("t3_grants", packed_gnt(), 64'h012012);
      chk("t3_bytes", packed_log(), 64'h404142404142);

      clear_logs();
      push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b0); push(0, 8'hA4, 1'b1);
      for (int k = 0; k < 40 && log_q.size() < 2; k++) tick();
      at_pos();
      tx_ready = 1'b0;
      stable = 1'b1;
      repeat (50) begin
         tick();
         if (req_ready != '0 || tx_data !== 8'hA3 || !tx_valid || !busy) stable = 1'b0;
      end
      chk("t4_stall_stable", 64'(stable), 1);
      chk("t4_nbytes_stall", 64'(log_q.size()), 2);
      at_pos();
      tx_ready = 1'b1;
      wait_pkts(1, 20);
      chk("t4_bytes", packed_log(), 64'hA1A2A3A4);
      chk("t4_nbytes", 64'(log_q.size()), 4);

      clear_logs();
      push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b0); push(1, 8'hB3, 1'b0); push(1, 8'hB4, 1'b1);
      for (int k = 0; k < 40 && log_q.size() < 2; k++) tick();
      chk("t5_grant_before", 64'(grant_id), 1);
      at_pos();
      rst = 1'b1;
      at_pos();
      tick();
      chk("t5_busy", 64'(busy), 0);
      chk("t5_grant", 64'(grant_id), 0);
      chk("t5_tx_valid", 64'(tx_valid), 0);
      chk("t5_tx_data", 64'(tx_data), 0);
      chk("t5_req_ready", 64'(req_ready), 0);
      chk("t5_pkt_done", 64'(pkt_done), 0);
      clear_logs();
      push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b0); push(1, 8'hB3, 1'b0); push(1, 8'hB4, 1'b1);
      push(0, 8'hC1, 1'b1);
      at_pos();
      rst = 1'b0;
      wait_pkts(2, 40);
      chk("t5_grants", packed_gnt(), 64'h01);
      chk("t5_bytes", packed_log(), 64'hC1B1B2B3B4);

`ifdef UART_ARB_TIMEOUT_EN
      do_reset();
      push(0, 8'hD1, 1'b0);
      push(1, 8'hE1, 1'b1);
      stall = 0;
      for (int k = 0; k < 60 && pkts < 1; k++) begin
         tick();
         if (busy && grant_id == 2'd0 && !tx_valid) stall++;
      end
      chk("t6_stall_cycles", 64'(stall), 16);
      chk("t6_pkts", 64'(pkts), 1);
      chk("t6_grants", packed_gnt(), 64'h01);
      chk("t6_bytes", packed_log(), 64'hD1E1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
